// File: rtl/pulse_hs_pkg.sv
// pulse_hs_pkg: shared types and default parameters for the pulse handshake source.
//   hs_state_e    - per-channel handshake FSM state (2 bits)
//   DefNumCh      - default channel count
//   DefCntW       - default pending-counter width
//   DefSyncStages - default ack synchroniser depth
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitLow = 2'd2
  } hs_state_e;

  localparam int unsigned DefNumCh      = 4;
  localparam int unsigned DefCntW       = 4;
  localparam int unsigned DefSyncStages = 2;

endpackage

// File: rtl/pulse_hs_ch.sv
// pulse_hs_ch: one channel of the four-phase pulse transfer source.
//   clka      - clock
//   rst       - synchronous active-high reset
//   pulse_i   - event input, one event per high cycle
//   ack_s_i   - synchronised acknowledge from the far side
//   ovf_clr_i - clears the sticky overflow flag
//   req_o     - request level (registered)
//   busy_o    - high while the FSM is not idle (registered)
//   pend_o    - events waiting for a handshake
//   ovf_o     - sticky flag, set when an event is lost to saturation
module pulse_hs_ch
  import pulse_hs_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             pulse_i,
  input  logic             ack_s_i,
  input  logic             ovf_clr_i,
  output logic             req_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pend_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] PendMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);

  hs_state_e        state_q;
  logic             req_q, busy_q, ovf_q;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             launch_ok, launch, ovf_set;

  // A new request may go out whenever there is work and the far side has released ack.
  assign launch_ok = (pulse_i | (|pend_q)) & ~ack_s_i;
  assign launch    = launch_ok & (state_q != StReq);

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (launch) begin
      // Without a same-cycle pulse the launch must have come from the backlog.
      // With a pulse, that pulse either feeds the launch or replaces the one taken.
      if (!pulse_i) begin
        pend_d = pend_q - PendOne;
      end
    end else if (pulse_i) begin
      if (pend_q == PendMax) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + PendOne;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      // A fresh overflow beats a same-cycle clear.
      ovf_q  <= ovf_set | (ovf_q & ~ovf_clr_i);
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StReq: begin
          if (ack_s_i) begin
            state_q <= StWaitLow;
            req_q   <= 1'b0;
          end
        end
        StWaitLow: begin
          if (launch) begin
            state_q <= StReq;
            req_q   <= 1'b1;
          end else if (!ack_s_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_o  = req_q;
  assign busy_o = busy_q;
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/sync_bit.sv
// sync_bit: single-bit multi-flop synchroniser into the clka domain.
//   clka - clock
//   rst  - synchronous active-high reset (clears every stage)
//   d_i  - asynchronous input bit
//   q_o  - synchronised output, SYNC_STAGES edges after d_i
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clka,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clka) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_hs_src.sv
// pulse_hs_src: multi-channel source side of a four-phase req/ack pulse transfer link.
//   clka      - clock
//   rst       - synchronous active-high reset
//   pulse_i   - per-channel event pulses
//   ack_i     - per-channel acknowledge, asynchronous to clka
//   ovf_clr_i - clears all overflow flags
//   req_o     - per-channel request level
//   busy_o    - per-channel handshake-in-progress
//   pend_o    - per-channel pending counts, channel k at [k*CNT_W +: CNT_W]
//   ovf_o     - per-channel sticky overflow
module pulse_hs_src
  import pulse_hs_pkg::*;
#(
  parameter int unsigned NUM_CH      = DefNumCh,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pulse_i,
  input  logic [NUM_CH-1:0]       ack_i,
  input  logic                    ovf_clr_i,
  output logic [NUM_CH-1:0]       req_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH*CNT_W-1:0] pend_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  logic [NUM_CH-1:0] ack_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clka(clka),
      .rst (rst),
      .d_i (ack_i[k]),
      .q_o (ack_s[k])
    );

    pulse_hs_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clka     (clka),
      .rst      (rst),
      .pulse_i  (pulse_i[k]),
      .ack_s_i  (ack_s[k]),
      .ovf_clr_i(ovf_clr_i),
      .req_o    (req_o[k]),
      .busy_o   (busy_o[k]),
      .pend_o   (pend_o[k*CNT_W +: CNT_W]),
      .ovf_o    (ovf_o[k])
    );
  end

endmodule

// File: tb/tb_pulse_hs_src.sv
module tb_pulse_hs_src;

  localparam int NCH  = 2;
  localparam int CW   = 3;
  localparam int MAXP = 7;
  localparam int DLY  = 3;

  logic              clka = 1'b0;
  logic              rst;
  logic [NCH-1:0]    pulse_i;
  logic [NCH-1:0]    ack_i;
  logic              ovf_clr_i;
  logic [NCH-1:0]    req_o;
  logic [NCH-1:0]    busy_o;
  logic [NCH*CW-1:0] pend_o;
  logic [NCH-1:0]    ovf_o;

  pulse_hs_src #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .SYNC_STAGES(2)
  ) dut (
    .clka     (clka),
    .rst      (rst),
    .pulse_i  (pulse_i),
    .ack_i    (ack_i),
    .ovf_clr_i(ovf_clr_i),
    .req_o    (req_o),
    .busy_o   (busy_o),
    .pend_o   (pend_o),
    .ovf_o    (ovf_o)
  );

  initial forever #5 clka = ~clka;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int pend;
    bit ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state
  int m_pend[NCH];
  bit m_ovf[NCH], m_req[NCH], m_s1[NCH], m_s2[NCH];
  int m_lost[NCH];
  // Monitor state
  int hs[NCH], bfall[NCH];
  logic [NCH-1:0] req_p, busy_p;
  // Responder state
  bit rs_ack[NCH];
  int rs_hi[NCH], rs_lo[NCH], hold[NCH];
  // Driver bookkeeping
  int pk[NCH];
  int ev[NCH];

  function automatic int pend_of(int k);
    return int'(pend_o[k*CW +: CW]);
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Cycle-level behaviour from the link rules: backlog = waiting events plus this cycle's pulse;
  // one leaves whenever no request is outstanding and ack is low; the rest is capped.
  task automatic model_loop();
    forever begin
      @(posedge clka);
      for (int k = 0; k < NCH; k++) begin
        if (rst) begin
          m_pend[k] = 0; m_ovf[k] = 0; m_req[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
        end else begin
          int b;
          bit go;
          exp_t e;
          b  = m_pend[k] + int'(pulse_i[k]);
          go = !m_req[k] && !m_s2[k] && (b > 0);
          if (m_req[k] && m_s2[k]) m_req[k] = 0;
          if (go) begin
            m_req[k] = 1;
            b = b - 1;
          end
          if (b > MAXP) begin
            b = MAXP;
            m_ovf[k] = 1;
            m_lost[k]++;
          end else if (ovf_clr_i) begin
            m_ovf[k] = 0;
          end
          m_pend[k] = b;
          if (go) begin
            e.pend = b;
            e.ovf  = m_ovf[k];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
          end
          m_s2[k] = m_s1[k];
          m_s1[k] = ack_i[k];
        end
      end
    end
  endtask

  // Every request rising edge must match a launch the model predicted.
  task automatic monitor_loop();
    forever begin
      @(negedge clka);
      for (int k = 0; k < NCH; k++) begin
        if (req_o[k] && !req_p[k]) begin
          int qs;
          exp_t e;
          hs[k]++;
          qs = (k == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            chk($sformatf("ch%0d unexpected launch", k), 1, 0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("ch%0d pend at launch", k), pend_of(k), e.pend);
            chk($sformatf("ch%0d ovf at launch", k), int'(ovf_o[k]), int'(e.ovf));
          end
        end
        if (busy_p[k] && !busy_o[k]) bfall[k]++;
      end
      req_p  = req_o;
      busy_p = busy_o;
    end
  endtask

  // Far side: raise ack DLY cycles after req is seen, drop it DLY cycles after req falls.
  task automatic responder_loop();
    forever begin
      @(negedge clka);
      for (int k = 0; k < NCH; k++) begin
        if (hold[k] > 0) begin
          hold[k]--;
          rs_ack[k] = (hold[k] != 0);
          rs_hi[k] = 0;
          rs_lo[k] = 0;
        end else if (!rs_ack[k]) begin
          rs_hi[k] = req_o[k] ? rs_hi[k] + 1 : 0;
          if (rs_hi[k] == DLY) begin rs_ack[k] = 1; rs_hi[k] = 0; end
        end else begin
          rs_lo[k] = !req_o[k] ? rs_lo[k] + 1 : 0;
          if (rs_lo[k] == DLY) begin rs_ack[k] = 0; rs_lo[k] = 0; end
        end
        ack_i[k] = rs_ack[k];
      end
    end
  endtask

  task automatic step();
    @(negedge clka);
    #1;
    for (int k = 0; k < NCH; k++) if (pend_of(k) > pk[k]) pk[k] = pend_of(k);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy_o != '0 || ack_i != '0) && n < 800) begin
      step();
      n++;
    end
    if (n >= 800) chk("drain timeout", 0, 1);
    repeat (4) step();
    chk("ch0 unmatched predicted launches", q0.size(), 0);
    chk("ch1 unmatched predicted launches", q1.size(), 0);
  endtask

  initial begin
    int h0[NCH];
    int b0[NCH];
    int l0[NCH];
    int n;
    rst = 1'b1; pulse_i = '0; ack_i = '0; ovf_clr_i = 1'b0;
    req_p = '0; busy_p = '0;
    for (int k = 0; k < NCH; k++) begin
      hs[k] = 0; bfall[k] = 0; rs_ack[k] = 0; rs_hi[k] = 0; rs_lo[k] = 0; hold[k] = 0;
      pk[k] = 0; ev[k] = 0; m_lost[k] = 0;
    end
    fork
      model_loop();
      monitor_loop();
      responder_loop();
    join_none

    repeat (3) step();
    chk("reset req_o", int'(req_o), 0);
    chk("reset busy_o", int'(busy_o), 0);
    chk("reset pend_o", int'(pend_o), 0);
    chk("reset ovf_o", int'(ovf_o), 0);
    rst = 1'b0;
    repeat (6) step();

    // Single pulse on channel 0
    for (int k = 0; k < NCH; k++) begin h0[k] = hs[k]; b0[k] = bfall[k]; pk[k] = 0; end
    pulse_i = 2'b01;
    step();
    pulse_i = 2'b00;
    chk("single: req_o[0] one cycle after pulse", int'(req_o[0]), 1);
    chk("single: busy_o[0] one cycle after pulse", int'(busy_o[0]), 1);
    drain();
    chk("single: ch0 handshakes", hs[0] - h0[0], 1);
    chk("single: ch1 handshakes", hs[1] - h0[1], 0);
    chk("single: busy_o[0] back low", int'(busy_o[0]), 0);
    chk("single: ch0 pend peak", pk[0], 0);
    chk("single: ch1 pend peak", pk[1], 0);

    // Burst of 5 on channel 1
    for (int k = 0; k < NCH; k++) begin h0[k] = hs[k]; b0[k] = bfall[k]; pk[k] = 0; end
    pulse_i = 2'b10;
    repeat (5) step();
    pulse_i = 2'b00;
    drain();
    chk("burst5: ch1 pend peak", pk[1], 4);
    chk("burst5: ch1 handshakes", hs[1] - h0[1], 5);
    chk("burst5: ch1 busy dropped once (back-to-back)", bfall[1] - b0[1], 1);
    chk("burst5: ovf_o[1]", int'(ovf_o[1]), 0);

    // Burst of 10 on channel 0: saturation
    for (int k = 0; k < NCH; k++) begin h0[k] = hs[k]; b0[k] = bfall[k]; pk[k] = 0; end
    pulse_i = 2'b01;
    repeat (10) step();
    pulse_i = 2'b00;
    chk("burst10: ovf_o[0] set", int'(ovf_o[0]), 1);
    drain();
    chk("burst10: ch0 pend peak", pk[0], MAXP);
    chk("burst10: ch0 handshakes", hs[0] - h0[0], 8);
    chk("burst10: ovf_o[0] still sticky", int'(ovf_o[0]), 1);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    chk("burst10: ovf_o after clear", int'(ovf_o), 0);

    // Pulse coinciding with WAIT_LOW relaunch at pend=2
    pulse_i = 2'b01;
    repeat (3) step();
    pulse_i = 2'b00;
    n = 0;
    while (!(!m_req[0] && !m_s2[0] && m_pend[0] == 2) && n < 40) begin
      step();
      n++;
    end
    chk("relaunch: window found", int'(n < 40), 1);
    pulse_i = 2'b01;
    step();
    pulse_i = 2'b00;
    chk("relaunch: req_o[0] immediate", int'(req_o[0]), 1);
    chk("relaunch: pend stays 2", pend_of(0), 2);
    drain();

    // Reset in REQ while the far side holds ack
    pulse_i = 2'b01;
    step();
    pulse_i = 2'b00;
    n = 0;
    while (!ack_i[0] && n < 20) begin step(); n++; end
    chk("rstmid: ack seen while in REQ", int'(ack_i[0] && req_o[0]), 1);
    rst = 1'b1;
    hold[0] = 6;
    step();
    rst = 1'b0;
    chk("rstmid: req_o[0] after reset", int'(req_o[0]), 0);
    repeat (3) step();
    pulse_i = 2'b01;
    step();
    pulse_i = 2'b00;
    chk("rstmid: pend after blocked pulse", pend_of(0), 1);
    n = 0;
    while (ack_i[0] && n < 20) begin
      chk("rstmid: req_o[0] low while ack high", int'(req_o[0]), 0);
      step();
      n++;
    end
    n = 0;
    while (!req_o[0] && n < 20) begin step(); n++; end
    chk("rstmid: cycles from ack fall to req rise", n, 3);
    drain();

    // Both channels, 3 cycles
    for (int k = 0; k < NCH; k++) h0[k] = hs[k];
    pulse_i = 2'b11;
    repeat (3) step();
    pulse_i = 2'b00;
    drain();
    chk("dual: ch0 handshakes", hs[0] - h0[0], 3);
    chk("dual: ch1 handshakes", hs[1] - h0[1], 3);

    // Randomised traffic at two loads
    for (int k = 0; k < NCH; k++) begin h0[k] = hs[k]; l0[k] = m_lost[k]; ev[k] = 0; end
    for (int seg = 0; seg < 2; seg++) begin
      for (int i = 0; i < 250; i++) begin
        int rate;
        rate = (seg == 0) ? 6 : 40;
        pulse_i[0] = ($urandom_range(0, 99) < rate);
        pulse_i[1] = ($urandom_range(0, 99) < rate);
        ovf_clr_i  = ($urandom_range(0, 39) == 0);
        for (int k = 0; k < NCH; k++) ev[k] += int'(pulse_i[k]);
        step();
      end
    end
    pulse_i = 2'b00;
    ovf_clr_i = 1'b0;
    drain();
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("random: ch%0d final pend", k), pend_of(k), m_pend[k]);
      chk($sformatf("random: ch%0d final ovf", k), int'(ovf_o[k]), int'(m_ovf[k]));
      chk($sformatf("random: ch%0d delivered+lost", k), (hs[k] - h0[k]) + (m_lost[k] - l0[k]),
          ev[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_hs_src.md
# pulse_hs_src

Multi-channel source side of a four-phase request/acknowledge pulse-transfer link. Single-cycle event pulses are turned into a level request per channel, with each request held until the far domain acknowledges it. Pulses that arrive while a handshake is in flight are counted rather than dropped. The block sits in the fast domain and pairs with a far-side responder that synchronises `req_o`, emits one output pulse per request and returns `ack`.

## Interface
- `NUM_CH`, default 4: number of independent channels (1..32).
- `CNT_W`, default 4: width of each channel's pending-pulse counter. Maximum backlog is 2^CNT_W−1.
- `SYNC_STAGES`, default 2: flop stages on each incoming `ack_i` bit (≥2).
- `clka` input, 1 bit: the only clock; all state is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `pulse_i` input, NUM_CH bits: per-channel event. Each high cycle is one event.
- `ack_i` input, NUM_CH bits: per-channel acknowledge from the far domain. It is asynchronous to `clka`.
- `ovf_clr_i` input, 1 bit: clears all `ovf_o` bits.
- `req_o` output, NUM_CH bits: per-channel request level, driven directly from a flop.
- `busy_o` output, NUM_CH bits: high while the channel FSM is not IDLE.
- `pend_o` output, NUM_CH*CNT_W bits: pending counts. Channel k occupies bits [k*CNT_W +: CNT_W].
- `ovf_o` output, NUM_CH bits: sticky flag, set when an event is lost.

## Operation
- Each `ack_i` bit passes through SYNC_STAGES flops to produce `ack_s`. Only `ack_s` is used internally.
- Each channel runs an FSM with three states:
  - IDLE: `req_o`=0.
  - REQ: `req_o`=1, waiting for `ack_s`=1.
  - WAIT_LOW: `req_o`=0, waiting for `ack_s`=0.
- Launch condition L = (`pulse_i` OR pend>0) AND `ack_s`=0.
- Transitions:
  - IDLE → REQ when L holds.
  - REQ → WAIT_LOW when `ack_s`=1.
  - WAIT_LOW → REQ when L holds. This is a direct relaunch with no idle cycle.
  - WAIT_LOW → IDLE when `ack_s`=0 and nothing is pending.
- A launch that is fed from the counter decrements pend. A launch that is fed by a same-cycle `pulse_i` with pend=0 leaves pend at 0.
- A pulse that is not consumed by a launch increments pend.
- When a launch and a pulse occur in the same cycle with pend>0, pend is unchanged.
- Saturation: if a pulse would increment pend beyond 2^CNT_W−1, pend stays at the maximum and `ovf_o[k]` is set.
- `ovf_clr_i` clears `ovf_o`. If a clear and a new overflow occur in the same cycle, the overflow wins.
- Channels are fully independent. There is no arbitration between them.
- Every event is delivered exactly once unless it is counted in `ovf_o`.

## Timing
- Reset values: `req_o`=0, `busy_o`=0, `pend_o`=0, `ovf_o`=0, all synchroniser flops 0, all FSMs in IDLE.
- Launch latency: `pulse_i` high in cycle n while the channel is IDLE with `ack_s`=0 gives `req_o`=1 and `busy_o`=1 from cycle n+1.
- Acknowledge latency: `ack_i` rising before edge m gives `ack_s`=1 after SYNC_STAGES edges. `req_o` falls one cycle later.
- Round trip: the minimum time per event is 2·(SYNC_STAGES+1) cycles plus the far-side latency.
- Reset mid-handshake:
  - `req_o` drops on the next edge and pend is cleared.
  - If the far side still holds `ack_i`=1, no launch occurs until `ack_s` returns to 0. Pulses received meanwhile accumulate in pend.
- A `pulse_i` level held for N cycles counts as N events.

## Structure
- Package `pulse_hs_pkg` holds:
  - the FSM state enum (IDLE, REQ, WAIT_LOW), 2 bits;
  - default parameter constants.
- Sub-module `pulse_hs_ch` implements one channel: the FSM, the counter and the overflow flag. It is instantiated NUM_CH times in a generate loop.
- Sub-module `sync_bit` is the SYNC_STAGES flop chain, instantiated once per `ack_i` bit.
- The top level contains only the generate loop and bus packing.

## Test plan
All scenarios use NUM_CH=2, CNT_W=3 and SYNC_STAGES=2. The bench responder returns `ack` 3 cycles after seeing `req`, and releases it 3 cycles after `req` falls.
- Single pulse on channel 0 at cycle 10:
  - `req_o[0]`=1 at cycle 11;
  - exactly one handshake completes;
  - `busy_o[0]` returns to 0;
  - pend stays 0 throughout;
  - channel 1 stays idle.
- Burst of 5 consecutive pulses on channel 1:
  - pend peaks at 4;
  - exactly 5 handshakes complete, each back-to-back through WAIT_LOW → REQ;
  - `ovf_o[1]`=0.
- Burst of 10 consecutive pulses on channel 0:
  - pend saturates at 7 and `ovf_o[0]`=1;
  - 8 handshakes complete;
  - pulsing `ovf_clr_i` returns `ovf_o[0]` to 0.
- Pulse arriving on the same cycle that WAIT_LOW sees `ack_s`=0 with pend=2:
  - the channel relaunches immediately;
  - pend stays 2.
- Reset asserted while in REQ, with `ack_i` held at 1 for 6 more cycles and a pulse during that window:
  - `req_o` is 0 after reset;
  - pend=1;
  - `req_o` rises only after `ack_s` returns to 0.
- Both channels pulsed simultaneously for 3 cycles:
  - the handshakes run independently;
  - 3 handshakes complete per channel.
